// File: rtl/data_reg_pkg.sv
// Shared types and sizing helpers for the data register bank.
package data_reg_pkg;

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_DEPTH  = 8;
  localparam int DEF_NUM_RD = 2;

  // Index width for a bank of 'depth' registers, never narrower than one bit.
  function automatic int addr_w(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/data_reg_rd_port.sv
// One registered read port: range check, optional write-through, zero when idle.
// DATA_REG_BANK_BYPASS_EN forwards same-cycle write data to a colliding read.
module data_reg_rd_port
  import data_reg_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = addr_w(DEF_DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        rd_en,
  input  logic [ADDR_W-1:0]           rd_addr,
  input  logic [DEPTH-1:0][WIDTH-1:0] regs,
`ifdef DATA_REG_BANK_BYPASS_EN
  input  logic                        wr_fire,
  input  logic [ADDR_W-1:0]           wr_addr,
  input  logic [WIDTH-1:0]            wr_data,
`endif
  output logic [WIDTH-1:0]            rd_data,
  output logic                        rd_valid
);

  logic             in_range;
  logic [WIDTH-1:0] rd_word;

  assign in_range = int'(rd_addr) < DEPTH;

  always_comb begin
    rd_word = '0;
    if (in_range) rd_word = regs[rd_addr];
`ifdef DATA_REG_BANK_BYPASS_EN
    // wr_fire already excludes writes issued while a clear is running
    if (in_range && wr_fire && (wr_addr == rd_addr)) rd_word = wr_data;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      rd_data  <= rd_en ? rd_word : '0;
    end
  end

endmodule

// File: rtl/data_reg_bank.sv
// Multi-read-port register bank with a sequential one-register-per-cycle bulk clear.
// DATA_REG_BANK_BYPASS_EN enables write-through forwarding on read/write collisions.
module data_reg_bank
  import data_reg_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int NUM_RD = DEF_NUM_RD,
  localparam int ADDR_W = addr_w(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*WIDTH-1:0]  rd_data,
  output logic [NUM_RD-1:0]        rd_valid,
  input  logic                     clr_req,
  output logic                     busy
);

  logic [DEPTH-1:0][WIDTH-1:0] regs;
  state_t                      state;
  logic [ADDR_W-1:0]           cnt;
  logic                        wr_fire;

  assign wr_fire = wr_en && !busy && (int'(wr_addr) < DEPTH);

  // A write coinciding with clr_req lands first; the clear then wipes it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs  <= '0;
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_fire) regs[wr_addr] <= wr_data;
          if (clr_req) begin
            state <= CLEAR;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        CLEAR: begin
          regs[cnt] <= '0;
          if (cnt == ADDR_W'(DEPTH - 1)) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + ADDR_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    data_reg_rd_port #(
      .WIDTH  (WIDTH),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
    ) u_rd (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_en    (rd_en[p]),
      .rd_addr  (rd_addr[p*ADDR_W +: ADDR_W]),
      .regs     (regs),
`ifdef DATA_REG_BANK_BYPASS_EN
      .wr_fire  (wr_fire),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
`endif
      .rd_data  (rd_data[p*WIDTH +: WIDTH]),
      .rd_valid (rd_valid[p])
    );
  end

endmodule

// File: tb/tb_data_reg_bank.sv
// Directed bench for data_reg_bank: default 8x8 two-port bank plus a DEPTH=6 single-port bank.
module tb_data_reg_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // default configuration: WIDTH 8, DEPTH 8, NUM_RD 2
  logic        wr_en_a, clr_a, busy_a;
  logic [2:0]  wr_addr_a;
  logic [7:0]  wr_data_a;
  logic [1:0]  rd_en_a, rd_valid_a;
  logic [5:0]  rd_addr_a;
  logic [15:0] rd_data_a;

  // short bank: WIDTH 8, DEPTH 6, NUM_RD 1
  logic        wr_en_b, clr_b, busy_b;
  logic [2:0]  wr_addr_b;
  logic [7:0]  wr_data_b;
  logic [0:0]  rd_en_b, rd_valid_b;
  logic [2:0]  rd_addr_b;
  logic [7:0]  rd_data_b;

  data_reg_bank #(.WIDTH(8), .DEPTH(8), .NUM_RD(2)) u_a (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
    .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a), .rd_valid(rd_valid_a),
    .clr_req(clr_a), .busy(busy_a)
  );

  data_reg_bank #(.WIDTH(8), .DEPTH(6), .NUM_RD(1)) u_b (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
    .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b), .rd_valid(rd_valid_b),
    .clr_req(clr_b), .busy(busy_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic write_a(input logic [2:0] addr, input logic [7:0] data);
    wr_en_a = 1'b1; wr_addr_a = addr; wr_data_a = data;
    step();
    wr_en_a = 1'b0;
  endtask

  logic [7:0] exp_coll;
  int         n_busy;

  initial begin
    rst_n = 1'b0;
    wr_en_a = 0; clr_a = 0; wr_addr_a = 0; wr_data_a = 0; rd_en_a = 0; rd_addr_a = 0;
    wr_en_b = 0; clr_b = 0; wr_addr_b = 0; wr_data_b = 0; rd_en_b = 0; rd_addr_b = 0;
    step(); step();
    chk("rst_busy", busy_a, 0);
    chk("rst_valid", rd_valid_a, 0);
    chk("rst_data", rd_data_a, 0);
    rst_n = 1'b1;

    // read of a freshly reset register
    rd_en_a = 2'b01; rd_addr_a = {3'd0, 3'd3};
    step();
    chk("rd3_valid", rd_valid_a, 2'b01);
    chk("rd3_data", rd_data_a, 16'h0000);
    chk("rd3_busy", busy_a, 0);
    rd_en_a = 2'b00;

    // write then dual-port read of the same address
    write_a(3'd5, 8'hA5);
    rd_en_a = 2'b11; rd_addr_a = {3'd5, 3'd5};
    step();
    chk("dual_valid", rd_valid_a, 2'b11);
    chk("dual_data", rd_data_a, 16'hA5A5);
    rd_en_a = 2'b00;
    step();
    chk("idle_valid", rd_valid_a, 2'b00);
    chk("idle_data", rd_data_a, 16'h0000);

    // same-cycle read/write collision
    write_a(3'd2, 8'h11);
`ifdef DATA_REG_BANK_BYPASS_EN
    exp_coll = 8'h3C;
`else
    exp_coll = 8'h11;
`endif
    wr_en_a = 1'b1; wr_addr_a = 3'd2; wr_data_a = 8'h3C;
    rd_en_a = 2'b01; rd_addr_a = {3'd0, 3'd2};
    step();
    wr_en_a = 1'b0;
    chk("coll_data", rd_data_a[7:0], exp_coll);
    step();
    chk("coll_after", rd_data_a[7:0], 8'h3C);
    rd_en_a = 2'b00;

    // fill the bank with 0x01, 0x11, ... 0x71
    for (int i = 0; i < 8; i++) write_a(3'(i), 8'(i * 16 + 1));
    rd_en_a = 2'b11; rd_addr_a = {3'd4, 3'd3};
    step();
    chk("fill_data", rd_data_a, 16'h4131);

    // clear with a simultaneous write of 0xFF to address 0
    rd_en_a = 2'b00;
    clr_a = 1'b1; wr_en_a = 1'b1; wr_addr_a = 3'd0; wr_data_a = 8'hFF;
    step();
    chk("clr_busy", busy_a, 1);
    n_busy = busy_a ? 1 : 0;
    // while busy: write and clr_req must be ignored, reads see pre-clear contents
    clr_a = 1'b1; wr_en_a = 1'b1; wr_addr_a = 3'd7; wr_data_a = 8'hEE;
    rd_en_a = 2'b11; rd_addr_a = {3'd7, 3'd0};
    step();
    clr_a = 1'b0; wr_en_a = 1'b0; rd_en_a = 2'b00;
    chk("busy_rd", rd_data_a, 16'h71FF);
    if (busy_a) n_busy++;
    while (busy_a && n_busy < 20) begin
      step();
      if (busy_a) n_busy++;
    end
    chk("busy_len", n_busy, 8);
    for (int i = 0; i < 8; i += 2) begin
      rd_en_a = 2'b11; rd_addr_a = {3'(i + 1), 3'(i)};
      step();
      chk("post_clr", {rd_valid_a, rd_data_a}, {2'b11, 16'h0000});
    end
    rd_en_a = 2'b00;

    // reset during the third clear cycle aborts the clear
    write_a(3'd6, 8'h5A);
    clr_a = 1'b1;
    step();
    clr_a = 1'b0;
    step(); step();
    rst_n = 1'b0;
    step();
    chk("abort_busy", busy_a, 0);
    rst_n = 1'b1;
    write_a(3'd1, 8'h77);
    rd_en_a = 2'b11; rd_addr_a = {3'd6, 3'd1};
    step();
    chk("abort_valid", rd_valid_a, 2'b11);
    chk("abort_data", rd_data_a, 16'h0077);
    rd_en_a = 2'b00;

    // DEPTH=6 bank: out-of-range write ignored, out-of-range read returns zero
    wr_en_b = 1'b1; wr_addr_b = 3'd7; wr_data_b = 8'h99;
    step();
    wr_addr_b = 3'd5; wr_data_b = 8'h42;
    step();
    wr_en_b = 1'b0;
    rd_en_b = 1'b1; rd_addr_b = 3'd7;
    step();
    chk("b_oor_valid", rd_valid_b, 1);
    chk("b_oor_data", rd_data_b, 8'h00);
    rd_addr_b = 3'd5;
    step();
    chk("b_rd5", rd_data_b, 8'h42);
    rd_addr_b = 3'd1;
    step();
    chk("b_rd1", rd_data_b, 8'h00);
    rd_en_b = 1'b0; rd_addr_b = 3'd5;
    step();
    chk("b_noen", {rd_valid_b, rd_data_b}, 9'h000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_reg_bank.md
DATA_REG_BANK -- requirements
Module: data_reg_bank

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving register data width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 8, giving the number of registers (2..256).
REQ-003 The block SHALL have parameter NUM_RD, default 2, giving the number of independent read ports (1..4).
REQ-004 The block SHALL have derived constant ADDR_W = clog2(DEPTH), minimum 1.
REQ-005 The block SHALL have a single clock, and its reset SHALL be synchronous and active-low, with ports as follows:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_W  write register index
- wr_data  in  WIDTH  write data
- rd_en  in  NUM_RD  per-port read request
- rd_addr  in  NUM_RD*ADDR_W  packed read indices, port p at [p*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*WIDTH  packed read data
- rd_valid  out  NUM_RD  per-port read-data-valid
- clr_req  in  1  request bulk clear of all registers
- busy  out  1  bulk clear in progress

Function
REQ-006 The block SHALL hold DEPTH registers of WIDTH bits.
REQ-007 Write: if wr_en=1, busy=0 and wr_addr<DEPTH at edge t, the register SHALL take wr_data, visible to reads issued at t+1.
REQ-008 A write with wr_addr>=DEPTH SHALL be ignored without side effect.
REQ-009 Read latency SHALL be 1 cycle: rd_en[p]=1 at edge t -> rd_valid[p]=1 and rd_data[p]=register contents after edge t+1; rd_valid[p]=0 after edge t+1 if rd_en[p]=0.
REQ-010 rd_data[p] SHALL be driven to all-zero whenever rd_valid[p]=0; no tristate outputs.
REQ-011 A read with rd_addr[p]>=DEPTH SHALL return all-zero data with rd_valid[p]=1.
REQ-012 All read ports SHALL operate concurrently and independently, including multiple ports reading the same address in the same cycle.
REQ-013 The FSM SHALL have states IDLE and CLEAR, and reset SHALL enter IDLE.
REQ-014 IDLE -> CLEAR SHALL occur on clr_req=1; the clear counter SHALL be loaded with 0; busy SHALL be 1 from the next cycle.
REQ-015 In CLEAR, one register per cycle (index = counter) SHALL be zeroed, with the counter incrementing; after index DEPTH-1 the FSM SHALL return to IDLE and busy SHALL fall. The clear therefore SHALL take exactly DEPTH cycles.
REQ-016 If clr_req and wr_en are both 1 in IDLE, the write SHALL be performed and the clear SHALL start the next cycle, so the written value is subsequently cleared.
REQ-017 While busy=1, wr_en SHALL be ignored, clr_req SHALL be ignored, and reads SHALL be served normally, returning current (partially cleared) contents.

Reset
REQ-018 On rst_n=0 at a clock edge, all registers, rd_data and rd_valid SHALL go to 0, busy SHALL go to 0, the counter SHALL go to 0, and the state SHALL go to IDLE.
REQ-019 Reset SHALL take priority over all other inputs, including mid-clear, which SHALL be aborted.

Configuration
REQ-020 With macro DATA_REG_BANK_BYPASS_EN defined, a read and a write to the same valid address in the same cycle SHALL return the new wr_data (write-through forwarding; not applied when busy=1).
REQ-021 Without DATA_REG_BANK_BYPASS_EN, the same collision SHALL return the old register value.

Structure
REQ-022 Package data_reg_pkg SHALL hold the FSM state type (IDLE, CLEAR), default WIDTH/DEPTH/NUM_RD constants, and the clog2-based ADDR_W helper.
REQ-023 Sub-module data_reg_rd_port SHALL implement one read port (address range check, bypass compare, output register, zero-on-invalid), instantiated NUM_RD times via generate.

Verification
REQ-024 Reset then read address 3 on port 0 -> rd_valid[0]=1 next cycle with rd_data[0]=0x00; busy=0.
REQ-025 Write 0xA5 to address 5, next cycle read address 5 on ports 0 and 1 -> both return 0xA5 one cycle later.
REQ-026 Same-cycle write 0x3C and read of address 2 (old value 0x11) -> 0x3C with DATA_REG_BANK_BYPASS_EN defined, 0x11 without.
REQ-027 Fill all 8 registers, assert clr_req with simultaneous write 0xFF to address 0 -> busy=1 for exactly 8 cycles; writes during busy are ignored; afterwards all reads return 0x00.
REQ-028 Assert rst_n=0 at clear cycle 3 -> busy=0 and state IDLE next cycle; all registers read 0x00.
REQ-029 DEPTH=6: write to address 7 is ignored; read of address 7 -> rd_valid=1 with rd_data=0; read with rd_en=0 -> rd_valid=0 and rd_data=0.
